// File: rtl/sc_mvm_pkg.sv
// Shared types and constants for the stochastic-computing MVM engine:
// FSM state encoding, SNG mode selectors and maximal-length LFSR tap masks.
package sc_mvm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int SNG_LFSR = 0;
    localparam int SNG_RAMP = 1;

    // Feedback taps for a shift-left Fibonacci LFSR; bit i set means r[i] feeds the XOR.
    function automatic logic [7:0] lfsr_taps(input int width);
        case (width)
            3:       return 8'h06;
            4:       return 8'h0C;
            5:       return 8'h14;
            6:       return 8'h30;
            7:       return 8'h60;
            8:       return 8'hB8;
            default: return 8'h0C;
        endcase
    endfunction

endpackage

// File: rtl/sc_sng.sv
// Stochastic number generator: a ramp counter or maximal-length LFSR compared
// against an offset-binary operand to produce one bipolar stream bit per cycle.
module sc_sng
    import sc_mvm_pkg::*;
#(
    parameter int X_W      = 4,
    parameter int SNG_MODE = SNG_LFSR
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           load,
    input  logic           step,
    input  logic [X_W-1:0] x_off,
    input  logic [X_W-1:0] seed,
    output logic           bit_o
);

    localparam logic [X_W-1:0] TAPS = X_W'(lfsr_taps(X_W));

    logic [X_W-1:0] r_q;
    logic [X_W-1:0] r_d;

    always_comb begin
        r_d = r_q;
        if (load) begin
            r_d = (SNG_MODE == SNG_RAMP) ? '0 : seed;
        end else if (step) begin
            if (SNG_MODE == SNG_RAMP) begin
                r_d = r_q + X_W'(1);
            end else begin
                r_d = {r_q[X_W-2:0], ^(r_q & TAPS)};
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= (SNG_MODE == SNG_RAMP) ? '0 : seed;
        end else begin
            r_q <= r_d;
        end
    end

    // The LFSR never reaches 0, so x_off = 0 (most negative x) always yields 0.
    assign bit_o = (r_q < x_off);

endmodule

// File: rtl/sc_mvm_array.sv
// Stochastic-computing vector-times-scalar engine with per-channel saturating
// up/down accumulators that can be cleared or chained across operations.
module sc_mvm_array
    import sc_mvm_pkg::*;
#(
    parameter int N_CH     = 4,
    parameter int X_W      = 4,
    parameter int W_W      = 6,
    parameter int ACC_W    = 8,
    parameter int SNG_MODE = 0,
    parameter int SEED     = 1
) (
    input  logic                  i_clk_smvm,
    input  logic                  i_rst_n_smvm,
    input  logic                  i_start,
    input  logic                  i_acc_clr,
    input  logic [N_CH*X_W-1:0]   i_x,
    input  logic [W_W-1:0]        i_w,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [N_CH*ACC_W-1:0] o_result,
    output logic [N_CH-1:0]       o_sat
);

    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    state_e                       state_q, state_d;
    logic                         busy_q, busy_d;
    logic                         done_q, done_d;
    logic [W_W-1:0]               cnt_q, cnt_d;
    logic [W_W-1:0]               wmag_q, wmag_d;
    logic                         wneg_q, wneg_d;
    logic [N_CH*X_W-1:0]          x_q, x_d;
    logic [N_CH-1:0][ACC_W-1:0]   acc_q, acc_d;
    logic [N_CH-1:0]              sat_q, sat_d;

    logic [W_W-1:0]               w_abs;
    logic                         start_ok;
    logic                         sng_step;
    logic [N_CH-1:0]              sng_bit;

    // The most negative weight maps to 2^(W_W-1), which still fits unsigned.
    assign w_abs    = i_w[W_W-1] ? (~i_w + W_W'(1)) : i_w;
    assign start_ok = (state_q == IDLE) && i_start;
    assign sng_step = (state_q == RUN);

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        localparam int SEED_C = ((SEED + c) % ((1 << X_W) - 1)) + 1;

        logic [X_W-1:0] x_c;
        assign x_c = x_q[c*X_W +: X_W];

        sc_sng #(
            .X_W      (X_W),
            .SNG_MODE (SNG_MODE)
        ) u_sng (
            .clk   (i_clk_smvm),
            .rst_n (i_rst_n_smvm),
            .load  (start_ok),
            .step  (sng_step),
            .x_off ({~x_c[X_W-1], x_c[X_W-2:0]}),
            .seed  (X_W'(SEED_C)),
            .bit_o (sng_bit[c])
        );
    end

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        cnt_d   = cnt_q;
        wmag_d  = wmag_q;
        wneg_d  = wneg_q;
        x_d     = x_q;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    x_d     = i_x;
                    wmag_d  = w_abs;
                    wneg_d  = i_w[W_W-1];
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = (w_abs != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                cnt_d = cnt_q + W_W'(1);
                if (cnt_q == wmag_q - W_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Steps are +-1, so saturation is simply refusing to move past a bound.
    always_comb begin
        acc_d = acc_q;
        sat_d = sat_q;
        if (start_ok && i_acc_clr) begin
            acc_d = '0;
            sat_d = '0;
        end else if (state_q == RUN) begin
            for (int c = 0; c < N_CH; c++) begin
                if (sng_bit[c] ^ wneg_q) begin
                    if (acc_q[c] == ACC_MAX) sat_d[c] = 1'b1;
                    else                     acc_d[c] = acc_q[c] + ACC_W'(1);
                end else begin
                    if (acc_q[c] == ACC_MIN) sat_d[c] = 1'b1;
                    else                     acc_d[c] = acc_q[c] - ACC_W'(1);
                end
            end
        end
    end

    always_ff @(posedge i_clk_smvm or negedge i_rst_n_smvm) begin
        if (!i_rst_n_smvm) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            wmag_q  <= '0;
            wneg_q  <= 1'b0;
            x_q     <= '0;
            acc_q   <= '0;
            sat_q   <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            wmag_q  <= wmag_d;
            wneg_q  <= wneg_d;
            x_q     <= x_d;
            acc_q   <= acc_d;
            sat_q   <= sat_d;
        end
    end

    assign o_busy   = busy_q;
    assign o_done   = done_q;
    assign o_result = acc_q;
    assign o_sat    = sat_q;

endmodule

// File: tb/tb_sc_mvm_array.sv
// Self-checking bench for sc_mvm_array: one ramp-mode and one LFSR-mode instance,
// table-driven operations with a result scoreboard plus hand-written corner cases.
module tb_sc_mvm_array;

    localparam int N_CH  = 4;
    localparam int X_W   = 4;
    localparam int W_W   = 6;
    localparam int ACC_W = 8;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  start_r = 1'b0;
    logic                  start_l = 1'b0;
    logic                  acc_clr = 1'b0;
    logic [N_CH*X_W-1:0]   x = '0;
    logic [W_W-1:0]        w = '0;

    logic                  busy_r, done_r, busy_l, done_l;
    logic [N_CH*ACC_W-1:0] res_r, res_l;
    logic [N_CH-1:0]       sat_r, sat_l;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    sc_mvm_array #(
        .N_CH(N_CH), .X_W(X_W), .W_W(W_W), .ACC_W(ACC_W), .SNG_MODE(1), .SEED(1)
    ) dut_ramp (
        .i_clk_smvm   (clk),
        .i_rst_n_smvm (rst_n),
        .i_start      (start_r),
        .i_acc_clr    (acc_clr),
        .i_x          (x),
        .i_w          (w),
        .o_busy       (busy_r),
        .o_done       (done_r),
        .o_result     (res_r),
        .o_sat        (sat_r)
    );

    sc_mvm_array #(
        .N_CH(N_CH), .X_W(X_W), .W_W(W_W), .ACC_W(ACC_W), .SNG_MODE(0), .SEED(1)
    ) dut_lfsr (
        .i_clk_smvm   (clk),
        .i_rst_n_smvm (rst_n),
        .i_start      (start_l),
        .i_acc_clr    (acc_clr),
        .i_x          (x),
        .i_w          (w),
        .o_busy       (busy_l),
        .o_done       (done_l),
        .o_result     (res_l),
        .o_sat        (sat_l)
    );

    typedef struct {
        logic [31:0] res;
        logic [3:0]  sat;
    } exp_t;

    typedef struct {
        logic        sel;
        logic [15:0] x;
        logic [5:0]  w;
        logic        clr;
        logic [31:0] res;
        logic [3:0]  sat;
        int          lat;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drives one operation, then compares latency, busy width, done pulse and the popped expectation.
    task automatic run_op(input logic sel, input logic [15:0] x_in, input logic [5:0] w_in,
                          input logic clr, input logic [31:0] res, input logic [3:0] sat,
                          input int lat, input string tag);
        exp_t e;
        exp_t p;
        int   n;
        int   busy_n;
        logic got;
        @(negedge clk);
        x = x_in;
        w = w_in;
        acc_clr = clr;
        if (sel) start_l = 1'b1;
        else     start_r = 1'b1;
        e.res = res;
        e.sat = sat;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        start_r = 1'b0;
        start_l = 1'b0;
        x = 16'($urandom);
        w = 6'($urandom);
        acc_clr = 1'($urandom);
        busy_n = (sel ? busy_l : busy_r) ? 1 : 0;
        got = 1'b0;
        n = 0;
        while (!got && n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (sel ? done_l : done_r) got = 1'b1;
            else if (sel ? busy_l : busy_r) busy_n++;
        end
        p = sb_q.pop_front();
        if (!got) begin
            check({tag, " done_timeout"}, 64'(0), 64'(1));
        end else begin
            check({tag, " done_latency"}, 64'(n), 64'(lat));
            check({tag, " busy_cycles"}, 64'(busy_n), 64'(lat));
            check({tag, " busy_at_done"}, 64'(sel ? busy_l : busy_r), 64'(0));
            check({tag, " result"}, 64'(sel ? res_l : res_r), 64'(p.res));
            check({tag, " sat"}, 64'(sel ? sat_l : sat_r), 64'(p.sat));
            @(posedge clk);
            #1;
            check({tag, " done_width"}, 64'(sel ? done_l : done_r), 64'(0));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   done_cnt;
        int   first_done;
        exp_t e;
        exp_t p;

        // x packing {ch3, ch2, ch1, ch0}; -8 is 4'h8.
        vecs[0]  = '{1'b0, 16'h7803, 6'd16,  1'b1, 32'h0EF00006, 4'h0, 17};
        vecs[1]  = '{1'b0, 16'h7803, 6'h30,  1'b0, 32'h00000000, 4'h0, 17};
        vecs[2]  = '{1'b0, 16'h7803, 6'd0,   1'b0, 32'h00000000, 4'h0, 1};
        vecs[3]  = '{1'b0, 16'h7777, 6'd31,  1'b1, 32'h1D1D1D1D, 4'h0, 32};
        vecs[4]  = '{1'b0, 16'h7777, 6'd31,  1'b0, 32'h3A3A3A3A, 4'h0, 32};
        vecs[5]  = '{1'b0, 16'h7777, 6'd31,  1'b0, 32'h57575757, 4'h0, 32};
        vecs[6]  = '{1'b0, 16'h7777, 6'd31,  1'b0, 32'h74747474, 4'h0, 32};
        vecs[7]  = '{1'b0, 16'h7777, 6'd31,  1'b0, 32'h7F7F7F7F, 4'hF, 32};
        vecs[8]  = '{1'b0, 16'h7777, 6'd31,  1'b1, 32'h1D1D1D1D, 4'h0, 32};
        vecs[9]  = '{1'b0, 16'h7777, 6'd0,   1'b0, 32'h1D1D1D1D, 4'h0, 1};
        vecs[10] = '{1'b0, 16'h7777, 6'h20,  1'b1, 32'hE4E4E4E4, 4'h0, 33};
        vecs[11] = '{1'b1, 16'h7878, 6'd15,  1'b1, 32'h0DF10DF1, 4'h0, 16};

        #1;
        check("reset busy", 64'(busy_r), 64'(0));
        check("reset done", 64'(done_r), 64'(0));
        check("reset result", 64'(res_r), 64'(0));
        check("reset sat", 64'(sat_r), 64'(0));
        check("reset lfsr result", 64'(res_l), 64'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].sel, vecs[i].x, vecs[i].w, vecs[i].clr,
                   vecs[i].res, vecs[i].sat, vecs[i].lat, $sformatf("vec%0d", i));
        end

        // Start pulse during RUN must be ignored; exactly one done at t+21.
        @(negedge clk);
        x = 16'h7803;
        w = 6'd20;
        acc_clr = 1'b1;
        start_r = 1'b1;
        e.res = 32'h12EC040A;
        e.sat = 4'h0;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        start_r = 1'b0;
        done_cnt = 0;
        first_done = 0;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk);
            #1;
            if (done_r) begin
                done_cnt++;
                if (first_done == 0) first_done = n;
            end
            if (n == 5) start_r = 1'b1;
            if (n == 6) start_r = 1'b0;
        end
        p = sb_q.pop_front();
        check("midrun_start done_count", 64'(done_cnt), 64'(1));
        check("midrun_start done_latency", 64'(first_done), 64'(21));
        check("midrun_start result", 64'(res_r), 64'(p.res));
        check("midrun_start sat", 64'(sat_r), 64'(p.sat));

        // Reset during RUN aborts asynchronously and no done follows.
        @(negedge clk);
        w = 6'd20;
        acc_clr = 1'b0;
        start_r = 1'b1;
        @(posedge clk);
        #1;
        start_r = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort busy", 64'(busy_r), 64'(0));
        check("abort done", 64'(done_r), 64'(0));
        check("abort result", 64'(res_r), 64'(0));
        check("abort sat", 64'(sat_r), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        done_cnt = 0;
        for (int n = 0; n < 30; n++) begin
            @(posedge clk);
            #1;
            if (done_r || busy_r) done_cnt++;
        end
        check("abort no_done_after", 64'(done_cnt), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
